// File: rtl/ballot_collector.sv
// Four-voter ballot collector: gathers latched yes presses over a fixed
// window and holds the final ballot until the downstream consumer acks it.
module ballot_collector #(
    parameter logic [15:0] WINDOW = 16'd100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] yes,
    input  logic       ack,
    output logic [3:0] I,
    output logic       valid,
    output logic       busy,
    output logic       early
);

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [15:0] cnt;
    logic [15:0] cnt_n;
    logic [3:0]  ballot_n;
    logic        early_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 16'd0;
            I     <= 4'b0000;
            early <= 1'b0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            I     <= ballot_n;
            early <= early_n;
            valid <= (state_n == HOLD);
            busy  <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ballot_n = I;
        early_n  = early;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n  = OPEN;
                    cnt_n    = WINDOW - 16'd1;
                    ballot_n = 4'b0000;
                    early_n  = 1'b0;
                end
            end
            OPEN: begin
                ballot_n = I | yes;
                // A full ballot in the last window cycle is a normal expiry.
                if (cnt == 16'd0) begin
                    state_n = HOLD;
                end else begin
                    cnt_n = cnt - 16'd1;
                    if (ballot_n == 4'b1111) begin
                        state_n = HOLD;
                        early_n = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (ack) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ballot_collector.sv
// Directed scoreboard bench for ballot_collector with WINDOW=4.
module tb_ballot_collector;

    localparam logic [15:0] W = 16'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] yes;
    logic       ack;
    logic [3:0] I;
    logic       valid;
    logic       busy;
    logic       early;

    ballot_collector #(.WINDOW(W)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .yes(yes),
        .ack(ack),
        .I(I),
        .valid(valid),
        .busy(busy),
        .early(early)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ballot;
        logic       early;
        int         lat;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t0 = 0;
    logic pv = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_s();
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && valid !== 1'b1; i++) tick();
        chk("wait_valid", valid, 1);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("ack_valid", valid, 0);
        chk("ack_busy", busy, 0);
    endtask

    task automatic push(logic [3:0] b, logic el, int lat);
        exp_t x;
        x.ballot = b;
        x.early = el;
        x.lat = lat;
        q.push_back(x);
    endtask

    // Monitor: each rising valid presents one ballot to the scoreboard.
    always @(negedge clk) begin
        if (valid === 1'b1 && pv !== 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ballot got %b want none", I);
            end else begin
                e = q.pop_front();
                chk("sb_ballot", I, e.ballot);
                chk("sb_early", early, e.early);
                chk("sb_latency", cyc - t0, e.lat);
            end
        end
        pv = valid;
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ack = 1'b0;
        yes = 4'b0000;
        #2;
        chk("rst_I", I, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_early", early, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Normal expiry, one press at cycle 2.
        push(4'b0011, 1'b0, 4);
        start_s();
        for (int k = 1; k <= 5; k++) begin
            yes = (k == 2) ? 4'b0011 : 4'b0000;
            chk("a_busy", busy, 1);
            chk("a_valid", valid, (k == 5) ? 1 : 0);
            if (k < 5) tick();
        end
        yes = 4'b0000;
        chk("a_early", early, 0);
        do_ack();

        // Early close on a full ballot in the first OPEN cycle.
        push(4'b1111, 1'b1, 1);
        start_s();
        yes = 4'b1111;
        tick();
        yes = 4'b0000;
        chk("e_valid", valid, 1);
        chk("e_early", early, 1);
        do_ack();

        // Press in last OPEN cycle counts; press in HOLD does not; ack in OPEN ignored.
        push(4'b0001, 1'b0, 4);
        start_s();
        ack = 1'b1;
        tick();
        tick();
        ack = 1'b0;
        tick();
        yes = 4'b0001;
        tick();
        yes = 4'b0010;
        tick();
        yes = 4'b0000;
        chk("l_I", I, 4'b0001);
        chk("l_valid", valid, 1);
        do_ack();

        // Ballot first complete in the final cycle is not early.
        push(4'b1111, 1'b0, 4);
        start_s();
        yes = 4'b0111;
        tick();
        yes = 4'b0000;
        tick();
        tick();
        yes = 4'b1000;
        tick();
        yes = 4'b0000;
        chk("f_early", early, 0);
        do_ack();

        // Long HOLD, then start together with ack.
        push(4'b0101, 1'b0, 4);
        start_s();
        yes = 4'b0101;
        tick();
        yes = 4'b0000;
        wait_valid();
        yes = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("h_valid", valid, 1);
            chk("h_I", I, 4'b0101);
        end
        yes = 4'b0000;
        start = 1'b1;
        ack = 1'b1;
        tick();
        start = 1'b0;
        ack = 1'b0;
        chk("sa_valid", valid, 0);
        chk("sa_busy", busy, 0);
        chk("sa_I", I, 4'b0101);
        yes = 4'b1111;
        tick();
        yes = 4'b0000;
        chk("sa_busy2", busy, 0);
        chk("idle_yes_I", I, 4'b0101);

        // Back-to-back sessions.
        push(4'b1010, 1'b0, 4);
        start_s();
        yes = 4'b1010;
        tick();
        yes = 4'b0000;
        wait_valid();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        push(4'b0000, 1'b0, 4);
        start_s();
        chk("b_I", I, 0);
        chk("b_busy", busy, 1);
        wait_valid();
        do_ack();

        // Asynchronous reset mid-OPEN.
        start_s();
        yes = 4'b0101;
        tick();
        yes = 4'b0000;
        chk("r_I_pre", I, 4'b0101);
        #2;
        rst = 1'b1;
        #1;
        chk("r_I", I, 0);
        chk("r_busy", busy, 0);
        chk("r_valid", valid, 0);
        chk("r_early", early, 0);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("r_idle_busy", busy, 0);
        end

        // Normal operation resumes after reset.
        push(4'b1100, 1'b0, 4);
        start_s();
        yes = 4'b1100;
        tick();
        yes = 4'b0000;
        wait_valid();
        do_ack();

        tick();
        tick();
        chk("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
